// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: FSM states,
// default bus widths, requester IDs and a counter-width helper.
package cpu_pkg;

    localparam int CPU_AW = 32;
    localparam int CPU_DW = 32;

    // Requester identifiers used by the grant logic.
    localparam logic REQ_ID_I = 1'b0;
    localparam logic REQ_ID_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Bits needed to hold values 0..n (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: counts cycles without a memory response.
// Ports: clk, rst (async active-low), clear, enable -> expire.
import cpu_pkg::*;

module mem_arb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = cnt_w(TIMEOUT);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    assign expire = (wait_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (enable && !expire) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port.
// Ports: i_* fetch side, d_* data side, mem_* registered memory port;
// clk, rst (async active-low). Data wins unless fetch is starved.
import cpu_pkg::*;

module mem_arbiter #(
    parameter int AW           = CPU_AW,
    parameter int DW           = CPU_DW,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready
);

    localparam int BW = DW / 8;
    localparam int SW = cnt_w(STARVE_LIMIT);

    arb_state_e state_q, state_d;

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic gnt_valid;
    logic gnt_id;
    logic starved;
    logic expire;
    logic busy;
    logic done;

    assign busy    = (state_q != IDLE);
    assign done    = mem_ready || expire;
    assign starved = (starve_cnt_q >= SW'(STARVE_LIMIT));

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy),
        .enable (busy && !mem_ready),
        .expire (expire)
    );

    // Grant selection, only meaningful in IDLE.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = REQ_ID_D;
        if (state_q == IDLE) begin
            unique case (1'b1)
                (i_req && d_req && starved): begin
                    gnt_valid = 1'b1;
                    gnt_id    = REQ_ID_I;
                end
                (i_req && d_req && !starved): begin
                    gnt_valid = 1'b1;
                    gnt_id    = REQ_ID_D;
                end
                (i_req && !d_req): begin
                    gnt_valid = 1'b1;
                    gnt_id    = REQ_ID_I;
                end
                (d_req && !i_req): begin
                    gnt_valid = 1'b1;
                    gnt_id    = REQ_ID_D;
                end
                default: begin
                    gnt_valid = 1'b0;
                end
            endcase
        end
    end

    // Next-state and registered memory-port fields.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid && gnt_id == REQ_ID_I) begin
                    state_d      = BUSY_I;
                    starve_cnt_d = '0;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_addr_d   = i_addr;
                    mem_wdata_d  = '0;
                end else if (gnt_valid) begin
                    state_d     = BUSY_D;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // Only count data grants that made fetch wait.
                    if (!i_req) begin
                        starve_cnt_d = '0;
                    end else if (!starved) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_req_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion outputs; a timeout returns zero data with err set.
    always_comb begin
        i_ack   = 1'b0;
        i_err   = 1'b0;
        i_rdata = '0;
        d_ack   = 1'b0;
        d_err   = 1'b0;
        d_rdata = '0;
        if (state_q == BUSY_I) begin
            i_ack   = done;
            i_err   = !mem_ready && expire;
            i_rdata = mem_ready ? mem_rdata : '0;
        end
        if (state_q == BUSY_D) begin
            d_ack   = done;
            d_err   = !mem_ready && expire;
            d_rdata = mem_ready ? mem_rdata : '0;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants while fetch waits before fetch is forced.
REQ-004 SHALL have parameter TIMEOUT, default 255, BUSY cycles without mem_ready before error completion.
REQ-005 SHALL have ports, one per line, as follows:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
i_req  in  1  fetch request, held until i_ack
i_addr  in  AW  fetch address
i_ack  out  1  fetch completion pulse
i_rdata  out  DW  fetch read data, valid with i_ack
i_err  out  1  fetch timed out, valid with i_ack
d_req  in  1  load/store request, held until d_ack
d_we  in  1  1 = store
d_be  in  DW/8  store byte enables
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  data completion pulse
d_rdata  out  DW  load data, valid with d_ack
d_err  out  1  data timed out, valid with d_ack
mem_req  out  1  memory request, registered
mem_we  out  1  memory write, registered
mem_be  out  DW/8  memory byte enables, registered
mem_addr  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only in BUSY

Function
REQ-006 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-007 In IDLE, with only i_req high, SHALL go to BUSY_I next edge and latch i_addr, mem_we=0, mem_be=all ones, mem_wdata=0.
REQ-008 In IDLE, with only d_req high, SHALL go to BUSY_D next edge and latch d_addr, d_we, d_be, d_wdata.
REQ-009 In IDLE, with both requests high, SHALL grant fetch if starve_cnt >= STARVE_LIMIT, else grant data.
REQ-010 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on a data grant while i_req is high.
REQ-011 starve_cnt SHALL clear on a fetch grant and on a data grant while i_req is low.
REQ-012 mem_req SHALL be 1 exactly while in BUSY_I or BUSY_D; mem_* fields SHALL stay stable throughout BUSY.
REQ-013 In BUSY_x with mem_ready=1, x_ack SHALL be 1 combinationally that cycle, x_rdata SHALL equal mem_rdata, x_err SHALL be 0, and the FSM SHALL return to IDLE next edge.
REQ-014 Minimum latency SHALL be request sampled at cycle t, mem_req at t+1, ack at t+1 when memory is zero-wait; one IDLE bubble SHALL separate back-to-back transactions.
REQ-015 wait_cnt SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ready.
REQ-016 When wait_cnt == TIMEOUT-1 and mem_ready=0, SHALL assert x_ack=1, x_err=1, x_rdata=0 and return to IDLE.
REQ-017 mem_ready in IDLE (late response) SHALL be ignored.
REQ-018 i_ack and d_ack SHALL never be 1 in the same cycle; a non-granted requester SHALL see ack=0, rdata=0, err=0.
REQ-019 A requester SHALL deassert req, or issue a new request, in the cycle after its ack; the arbiter SHALL treat any req high in IDLE as new.

Reset
REQ-020 rst=0 SHALL asynchronously force state IDLE, starve_cnt=0, wait_cnt=0, all mem_* outputs=0; all ack/err/rdata outputs SHALL be 0.
REQ-021 Reset during BUSY SHALL abandon the transaction with no ack; requesters SHALL reissue after reset.
REQ-022 The first grant SHALL be possible on the first rising edge with rst=1.

Structure
REQ-023 State encoding, AW/DW defaults and the requester-ID constants SHALL live in shared package cpu_pkg.
REQ-024 The timeout counter SHALL be sub-module mem_arb_wdog (inputs clear/enable; output expire).

Verification
REQ-025 i_req, i_addr=0x100, mem_ready=1 constant -> mem_req high at t+1 with mem_addr=0x100, mem_we=0; i_ack=1 at t+1 with i_rdata=mem_rdata.
REQ-026 i_req and d_req both held continuously, mem_ready=1 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-027 d_req, d_we=1, d_be=0011, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_* stable 4 cycles; d_ack on 4th BUSY cycle; i_ack stays 0.
REQ-028 d_req, mem_ready=0 forever, TIMEOUT=8 -> d_ack=1, d_err=1, d_rdata=0 on 8th BUSY cycle; mem_ready pulse next cycle is ignored.
REQ-029 rst=0 asserted mid-BUSY_I -> mem_req=0 immediately, no i_ack; after release, held i_req is regranted.
